panel_scroll_driver: RTL



---
 rtl/panel_scroll_driver_pkg.sv | 12 +
 rtl/panel_scroll_driver_if.sv | 39 +++
 rtl/panel_scroll_driver_tick_divider.sv | 29 ++
 rtl/panel_scroll_driver.sv | 114 +++++++++++
 4 files changed

// File: rtl/panel_scroll_driver_pkg.sv
// Shared types for the scrolling word panel driver.
// Column data is active-low: a set bit is an unlit row, so 7'h7F is a dark column.
package panel_pkg;

    typedef logic [6:0] col_t;

    localparam col_t BLANK_COL = 7'h7F;

    // Scan slot phase: one dark cycle, then the column is shown.
    typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/panel_scroll_driver_if.sv
// Column-mux and panel-drive signal bundle for panel_scroll_driver.
// Optional macro SCROLL_PAUSE_EN adds the PAUSE input.
//
// Timing contract (no valid/ready handshake on this path): the driver
// (master) presents SEL from a register. The mux (slave) returns D_IN
// combinationally from SEL. The driver samples D_IN only on a scroll tick,
// which is at least one full scroll period after SEL last changed. ROW_OUT
// and COL_EN are level outputs to the panel pins.
interface panel_scroll_driver_if #(
    parameter int NUM_COLS = 24
);
    import panel_pkg::*;

    logic [6:0]          SEL;
    col_t                D_IN;
    col_t                ROW_OUT;
    logic [NUM_COLS-1:0] COL_EN;
    logic                WRAP;
`ifdef SCROLL_PAUSE_EN
    logic                PAUSE;
`endif

    modport master (
        output SEL, ROW_OUT, COL_EN, WRAP,
`ifdef SCROLL_PAUSE_EN
        input  PAUSE,
`endif
        input  D_IN
    );

    modport slave (
        input  SEL, ROW_OUT, COL_EN, WRAP,
`ifdef SCROLL_PAUSE_EN
        output PAUSE,
`endif
        output D_IN
    );

endinterface

// File: rtl/panel_scroll_driver_tick_divider.sv
// Free-running divider: counts 0..DIV-1 while EN is high and holds while EN
// is low. TICK is high on the enabled cycle whose count is DIV-1, so the next
// edge both wraps the count and performs whatever the tick triggers.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic TICK
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // Count with explicit compare-and-clear so a non-power-of-two DIV never overflows.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (EN) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign TICK = EN && (count == LAST);

endmodule

// File: rtl/panel_scroll_driver.sv
// Scrolling word panel driver: walks SEL through the message, shifts the
// returned column into a frame buffer from the right, and scans the buffer
// onto the LED matrix with one dark cycle between columns.
// Optional macro SCROLL_PAUSE_EN: adds PAUSE, which freezes scrolling only.
module panel_scroll_driver
    import panel_pkg::*;
#(
    parameter int NUM_COLS   = 24,
    parameter int MSG_LEN    = 72,
    parameter int SCROLL_DIV = 5000000,
    parameter int SCAN_DIV   = 2000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   EN,
    panel_scroll_driver_if.master  bus,
    output scan_state_t            dbg_state
);

    localparam int                  CW       = $clog2(NUM_COLS);
    localparam logic [CW-1:0]       COL_LAST = CW'(NUM_COLS - 1);
    localparam logic [6:0]          SEL_LAST = 7'(MSG_LEN - 1);
    localparam logic [NUM_COLS-1:0] ONE_COL  = NUM_COLS'(1);

    col_t                frame [NUM_COLS];
    logic [6:0]          sel;
    logic                scroll_run;
    logic                scroll_tick;
    logic                scan_tick;
    scan_state_t         state;
    logic [CW-1:0]       scan_col;
    col_t                row_q;
    logic [NUM_COLS-1:0] col_q;

`ifdef SCROLL_PAUSE_EN
    assign scroll_run = EN && !bus.PAUSE;
`else
    assign scroll_run = EN;
`endif

    tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (scroll_run),
        .TICK  (scroll_tick)
    );

    // Scan slot timing keeps running while scrolling is paused.
    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .TICK  (scan_tick)
    );

    // On each scroll tick, shift the frame left, take D_IN for the current SEL, and advance SEL.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                frame[i] <= BLANK_COL;
            end
            sel <= '0;
        end else if (scroll_tick) begin
            for (int i = 0; i < NUM_COLS - 1; i++) begin
                frame[i] <= frame[i+1];
            end
            frame[NUM_COLS-1] <= bus.D_IN;
            sel <= (sel == SEL_LAST) ? '0 : sel + 7'd1;
        end
    end

    // Scan FSM: BLANK lasts one cycle, SHOW lasts until the scan tick, then step the column.
    // While showing, the row drive is refreshed every cycle so a scroll shift appears one cycle later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= BLANK;
            scan_col <= '0;
            row_q    <= BLANK_COL;
            col_q    <= '0;
        end else if (EN) begin
            case (state)
                BLANK: begin
                    state <= SHOW;
                    row_q <= frame[scan_col];
                    col_q <= ONE_COL << scan_col;
                end
                SHOW: begin
                    if (scan_tick) begin
                        state    <= BLANK;
                        row_q    <= BLANK_COL;
                        col_q    <= '0;
                        scan_col <= (scan_col == COL_LAST) ? '0 : scan_col + 1'b1;
                    end else begin
                        row_q <= frame[scan_col];
                        col_q <= ONE_COL << scan_col;
                    end
                end
                default: begin
                    state <= BLANK;
                    row_q <= BLANK_COL;
                    col_q <= '0;
                end
            endcase
        end
    end

    // EN low darkens the panel at once and resumes from the held registers when EN returns.
    assign bus.SEL     = sel;
    assign bus.WRAP    = scroll_tick && (sel == SEL_LAST);
    assign bus.ROW_OUT = EN ? row_q : BLANK_COL;
    assign bus.COL_EN  = EN ? col_q : '0;
    assign dbg_state   = state;

endmodule
